// File: rtl/tx_serial_7n1_arbitro_if.sv
`default_nettype none
// ============================================================================
//  Module   : tx_serial_7n1_arbitro_if
//  Purpose  : Bundles the requester handshake and the transmit-datapath
//             control lines of the 7N1 serial transmit arbiter.
//  Signals  : pedido      - per-requester transmit request (level)
//             dados_in    - requester i word at bits [7i+6:7i]
//             concedido   - one-hot grant, one-cycle pulse
//             pronto      - one-cycle pulse at end of frame
//             ocupado     - high while a frame is in progress
//             fim         - datapath bit counter reached 10
//             zera        - clear of the datapath bit counter
//             carrega     - parallel load of the frame shift register
//             desloca     - shift of the frame shift register
//             conta       - datapath bit counter increment
//             dados_ascii - latched word presented to the datapath
//             db_estado   - current controller state (debug)
//  Modports : slave  - the controller (tx_serial_7n1_arbitro)
//             master - the environment (requesters + datapath)
//  Revision : 1.0 - initial release
// ============================================================================
interface tx_serial_7n1_arbitro_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   pedido;
    logic [7*NUM_REQ-1:0] dados_in;
    logic [NUM_REQ-1:0]   concedido;
    logic                 pronto;
    logic                 ocupado;
    logic                 fim;
    logic                 zera;
    logic                 carrega;
    logic                 desloca;
    logic                 conta;
    logic [6:0]           dados_ascii;
    logic [3:0]           db_estado;

    modport slave (
        input  pedido, dados_in, fim,
        output concedido, pronto, ocupado, zera, carrega, desloca, conta,
               dados_ascii, db_estado
    );

    modport master (
        output pedido, dados_in, fim,
        input  concedido, pronto, ocupado, zera, carrega, desloca, conta,
               dados_ascii, db_estado
    );
endinterface
`default_nettype wire

// File: rtl/tx_serial_7n1_arbitro.sv
`default_nettype none
// ============================================================================
//  Module   : tx_serial_7n1_arbitro
//  Purpose  : Control unit of a 7N1 serial transmitter shared by NUM_REQ
//             requesters. Arbitrates requests, latches the winning 7-bit
//             word, generates the baud tick and sequences the datapath
//             (zera/carrega/desloca/conta) until the frame ends.
//  Ports    : clock  - system clock, rising edge
//             reset  - synchronous, active-low reset
//             tx_if  - slave modport of tx_serial_7n1_arbitro_if
//  Macro    : TX_PRIORIDADE_FIXA_EN - when defined, fixed priority (lowest
//             index wins) replaces round-robin and no pointer is built.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_serial_7n1_arbitro #(
    parameter int NUM_REQ  = 2,
    parameter int BAUD_DIV = 434,
    parameter int W_BAUD   = 9
) (
    input  wire logic              clock,
    input  wire logic              reset,
    tx_serial_7n1_arbitro_if.slave tx_if
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [3:0] S_INICIAL     = 4'd0;
    localparam logic [3:0] S_PREPARACAO  = 4'd1;
    localparam logic [3:0] S_ESPERA      = 4'd2;
    localparam logic [3:0] S_TRANSMISSAO = 4'd3;
    localparam logic [3:0] S_FINAL       = 4'd4;

    localparam logic [W_BAUD-1:0] C_BAUD_LAST = W_BAUD'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(NUM_REQ - 1);

    logic [3:0]        estado_q,   estado_d;
    logic [W_BAUD-1:0] baud_q,     baud_d;
    logic [IDX_W-1:0]  vencedor_q, vencedor_d;
    logic [6:0]        dados_q,    dados_d;

    logic              w_tick;
    logic [W_BAUD-1:0] w_baud_prox;
    logic              w_algum;
    logic [IDX_W-1:0]  w_escolha;

    // Baud counter wraps on the tick so bit periods stay exactly BAUD_DIV
    // cycles regardless of which state the tick lands in.
    assign w_tick      = (baud_q == C_BAUD_LAST);
    assign w_baud_prox = w_tick ? '0 : baud_q + 1'b1;

`ifdef TX_PRIORIDADE_FIXA_EN
    // Fixed priority: scan downward so the lowest set index is the last hit.
    always_comb begin
        w_algum   = 1'b0;
        w_escolha = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (tx_if.pedido[i]) begin
                w_algum   = 1'b1;
                w_escolha = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ponteiro_q, ponteiro_d;
    int               w_j;

    // Round-robin: candidate k is (pointer + k) mod NUM_REQ. Scanning k
    // downward leaves the candidate closest to the pointer as the winner.
    always_comb begin
        w_algum   = 1'b0;
        w_escolha = '0;
        w_j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(ponteiro_q) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (tx_if.pedido[w_j]) begin
                w_algum   = 1'b1;
                w_escolha = IDX_W'(w_j);
            end
        end
    end

    always_comb begin
        ponteiro_d = ponteiro_q;
        if (estado_q == S_FINAL) begin
            ponteiro_d = (vencedor_q == C_IDX_LAST) ? '0 : vencedor_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ponteiro_q <= '0;
        end else begin
            ponteiro_q <= ponteiro_d;
        end
    end
`endif

    always_comb begin
        estado_d   = estado_q;
        baud_d     = baud_q;
        vencedor_d = vencedor_q;
        dados_d    = dados_q;
        case (estado_q)
            S_INICIAL: begin
                baud_d = '0;
                if (w_algum) begin
                    vencedor_d = w_escolha;
                    dados_d    = tx_if.dados_in[7*int'(w_escolha) +: 7];
                    estado_d   = S_PREPARACAO;
                end
            end
            S_PREPARACAO: begin
                baud_d   = '0;
                estado_d = S_ESPERA;
            end
            S_ESPERA: begin
                baud_d = w_baud_prox;
                if (w_tick) begin
                    estado_d = tx_if.fim ? S_FINAL : S_TRANSMISSAO;
                end
            end
            S_TRANSMISSAO: begin
                baud_d   = w_baud_prox;
                estado_d = S_ESPERA;
            end
            S_FINAL: begin
                baud_d   = w_baud_prox;
                estado_d = S_INICIAL;
            end
            default: begin
                baud_d   = '0;
                estado_d = S_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q   <= S_INICIAL;
            baud_q     <= '0;
            vencedor_q <= '0;
            dados_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            baud_q     <= baud_d;
            vencedor_q <= vencedor_d;
            dados_q    <= dados_d;
        end
    end

    // Moore outputs decoded from the state register only.
    assign tx_if.concedido   = (estado_q == S_PREPARACAO) ?
                               (NUM_REQ'(1) << vencedor_q) : '0;
    assign tx_if.zera        = (estado_q == S_PREPARACAO);
    assign tx_if.carrega     = (estado_q == S_PREPARACAO);
    assign tx_if.desloca     = (estado_q == S_TRANSMISSAO);
    assign tx_if.conta       = (estado_q == S_TRANSMISSAO);
    assign tx_if.pronto      = (estado_q == S_FINAL);
    assign tx_if.ocupado     = (estado_q == S_PREPARACAO) || (estado_q == S_ESPERA) ||
                               (estado_q == S_TRANSMISSAO) || (estado_q == S_FINAL);
    assign tx_if.dados_ascii = dados_q;
    assign tx_if.db_estado   = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_serial_7n1_arbitro.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_serial_7n1_arbitro
//  Purpose  : Self-checking bench for tx_serial_7n1_arbitro. Random request
//             patterns feed a scoreboard of expected grants; a monitor checks
//             each frame's timeline. Directed sections cover a forced fim,
//             a mid-frame reset and pointer restart.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_serial_7n1_arbitro;
    localparam int N  = 3;
    localparam int BD = 4;
    localparam int WB = 3;

    typedef struct {
        int         win;
        logic [6:0] data;
        bit         b2b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic force_fim;
    logic [3:0] bitcnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tx_serial_7n1_arbitro_if #(.NUM_REQ(N)) bus();

    tx_serial_7n1_arbitro #(.NUM_REQ(N), .BAUD_DIV(BD), .W_BAUD(WB)) dut (
        .clock (clk),
        .reset (rst_n),
        .tx_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmit datapath stand-in: mod-11 bit counter producing fim.
    always @(posedge clk) begin
        if (!rst_n)             bitcnt <= 4'd0;
        else if (bus.zera)      bitcnt <= 4'd0;
        else if (bus.conta)     bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
    end
    assign bus.fim = force_fim | (bitcnt == 4'd10);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout at cycle %0d", nm, cyc);
    endtask

    // Reference arbitration: first requester at or after the pointer.
    function automatic int pick(input logic [N-1:0] m, input int p);
        int i;
`ifdef TX_PRIORIDADE_FIXA_EN
        p = 0;
`endif
        for (int k = 0; k < N; k++) begin
            i = (p + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- scoreboard + monitor ----------------
    exp_t exp_q[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;
    int   fc = -1;
    int   grant_cnt = 0;
    int   last_pronto = -100;
    logic [6:0] cur_data;
    bit   exp_d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.concedido != '0) begin
                chk("grant_overlap", fc, -1);
                if (exp_q.size() == 0) begin
                    fail_timeout("unexpected_grant");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_onehot", int'(bus.concedido), 1 << mon_e.win);
                    chk("grant_data", int'(bus.dados_ascii), int'(mon_e.data));
                    chk("grant_zera_carrega", int'({bus.zera, bus.carrega}), 3);
                    chk("grant_ocupado", int'(bus.ocupado), 1);
                    if (mon_e.b2b) chk("grant_gap_after_pronto", cyc - last_pronto, 2);
                    cur_data = mon_e.data;
                end
                fc = 0;
                grant_cnt++;
            end else if (fc >= 0) begin
                fc++;
                exp_d = (fc > BD) && (fc <= 10*BD + 1) && (((fc - 1) % BD) == 0);
                chk("frame_desloca", int'(bus.desloca), int'(exp_d));
                chk("frame_conta", int'(bus.conta), int'(exp_d));
                chk("frame_pronto", int'(bus.pronto), int'(fc == 11*BD + 1));
                chk("frame_ocupado", int'(bus.ocupado), 1);
                chk("frame_zc", int'({bus.zera, bus.carrega}), 0);
                chk("frame_data_stable", int'(bus.dados_ascii), int'(cur_data));
                if (fc == 11*BD + 1) begin
                    last_pronto = cyc;
                    fc = -1;
                end
            end else begin
                chk("idle_outputs", int'({bus.pronto, bus.ocupado, bus.zera, bus.carrega,
                                          bus.desloca, bus.conta}), 0);
                chk("idle_state", int'(bus.db_estado), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] mask;
    logic [6:0]   word [N];
    int           rr;
    int           pend_win;

    task automatic drive();
        for (int i = 0; i < N; i++) bus.dados_in[7*i +: 7] = word[i];
        bus.pedido = mask;
    endtask

    task automatic push_exp(input bit b2b);
        exp_t e;
        e.win  = pick(mask, rr);
        e.data = word[e.win];
        e.b2b  = b2b;
        exp_q.push_back(e);
        pend_win = e.win;
    endtask

    task automatic wait_grant(input int exp_g, input int exp_dat, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 14*BD; i++) begin
            @(negedge clk);
            if (bus.concedido != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_timeout({nm, "_grant"});
        else begin
            chk({nm, "_grant"}, int'(bus.concedido), exp_g);
            chk({nm, "_data"}, int'(bus.dados_ascii), exp_dat);
        end
    endtask

    task automatic wait_pronto(output int n, output int nd);
        n  = -1;
        nd = 0;
        for (int i = 1; i <= 12*BD + 4; i++) begin
            @(negedge clk);
            if (bus.desloca) nd++;
            if (bus.pronto) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int  f;
        bit  tmo;
        int  n, nd;
        rst_n      = 1'b0;
        force_fim  = 1'b0;
        mask       = '0;
        bus.pedido   = '0;
        bus.dados_in = '0;
        for (int i = 0; i < N; i++) word[i] = 7'h00;
        rr = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(bus.db_estado), 0);
        chk("reset_outputs", int'({bus.concedido, bus.pronto, bus.ocupado, bus.zera,
                                   bus.carrega, bus.desloca, bus.conta}), 0);
        chk("reset_data", int'(bus.dados_ascii), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // -------- randomized scoreboard phase --------
        f   = 0;
        tmo = 1'b0;
        while ((f < 14 || mask != '0) && f < 40 && !tmo) begin
            if (mask == '0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                #1;
                mask = N'($urandom_range(1, (1 << N) - 1));
                for (int i = 0; i < N; i++) if (mask[i]) word[i] = 7'($urandom);
                drive();
                push_exp(1'b0);
            end
            tmo = 1'b1;
            for (int c = 0; c < 14*BD; c++) begin
                @(negedge clk);
                #1;
                if (grant_cnt > f) begin
                    tmo = 1'b0;
                    break;
                end
            end
            if (tmo) begin
                fail_timeout("random_grant");
            end else begin
                mask[pend_win] = 1'b0;
                if (f < 13 && $urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < N; i++) begin
                        if (!mask[i] && $urandom_range(0, 1) == 1) begin
                            mask[i] = 1'b1;
                            word[i] = 7'($urandom);
                        end
                    end
                end
                drive();
`ifndef TX_PRIORIDADE_FIXA_EN
                rr = (pend_win + 1) % N;
`endif
                if (mask != '0) push_exp(1'b1);
            end
            f++;
        end
        tmo = 1'b1;
        for (int c = 0; c < 14*BD; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && fc == -1) begin
                tmo = 1'b0;
                break;
            end
        end
        if (tmo) fail_timeout("random_drain");
        @(negedge clk);
        #1;
        mon_en = 1'b0;

        // -------- fim forced at the first tick --------
        word[0] = 7'h41;
        mask    = 3'b001;
        drive();
        wait_grant(1, 7'h41, "fim");
        mask = '0;
        drive();
        force_fim = 1'b1;
        wait_pronto(n, nd);
        chk("fim_pronto_cycle", n, BD + 1);
        chk("fim_no_desloca", nd, 0);
        chk("fim_final_state", int'(bus.db_estado), 4);
        force_fim = 1'b0;
        @(negedge clk);
        chk("fim_back_to_idle", int'(bus.db_estado), 0);

        // -------- full frame for requester 1 (pointer moves to 2) --------
        word[1] = 7'h42;
        mask    = 3'b010;
        drive();
        wait_grant(2, 7'h42, "req1");
        mask = '0;
        drive();
        wait_pronto(n, nd);
        chk("req1_pronto_cycle", n, 11*BD + 1);
        chk("req1_desloca_count", nd, 10);

        // -------- reset in the middle of a frame --------
        word[2] = 7'h43;
        mask    = 3'b100;
        drive();
        wait_grant(4, 7'h43, "req2");
        mask = '0;
        drive();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_state", int'(bus.db_estado), 0);
        chk("midreset_outputs", int'({bus.concedido, bus.pronto, bus.ocupado, bus.zera,
                                      bus.carrega, bus.desloca, bus.conta}), 0);
        chk("midreset_data", int'(bus.dados_ascii), 0);
        rst_n   = 1'b1;
        word[0] = 7'h51;
        word[2] = 7'h52;
        mask    = 3'b101;
        drive();
        wait_grant(1, 7'h51, "after_reset");
        mask = '0;
        drive();
        wait_pronto(n, nd);
        chk("after_reset_pronto_cycle", n, 11*BD + 1);
        chk("after_reset_data_hold", int'(bus.dados_ascii), 7'h51);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/tx_serial_7n1_arbitro.md
Name: tx_serial_7N1_arbitro

Overview:
Control unit that sequences the 7N1 serial transmit datapath (11-bit frame shift register plus mod-11 bit counter). It shares that datapath between NUM_REQ requesters. The block arbitrates requests, latches the winner's 7-bit ASCII word, generates the internal baud tick, and drives zera/carrega/desloca/conta until the frame ends. It sits between the requesting units and the transmit datapath, one instance per serial line.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BAUD_DIV, 434, clock cycles per serial bit (>=2); 434 = 50 MHz / 115200
W_BAUD, 9, width of the baud counter; must satisfy 2**W_BAUD >= BAUD_DIV

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
pedido  in  NUM_REQ  per-requester transmit request, level; held until the matching concedido
dados_in  in  7*NUM_REQ  requester i word at bits [7i+6:7i]
concedido  out  NUM_REQ  one-hot grant, one-cycle pulse
pronto  out  1  one-cycle pulse at end of frame
ocupado  out  1  high whenever a frame is in progress
fim  in  1  terminal flag of the datapath bit counter (counter value == 10)
zera  out  1  synchronous clear of the bit counter
carrega  out  1  parallel load of the frame shift register
desloca  out  1  shift of the frame shift register
conta  out  1  bit counter increment
dados_ascii  out  7  latched word presented to the datapath
db_estado  out  4  current state code (debug)

Behaviour:
- Reset (reset=0 at a rising edge):
  - State becomes inicial.
  - All outputs are 0.
  - Baud counter, round-robin pointer, winner index and data register are cleared.
  - Reset overrides any frame in progress. The datapath is not driven further after reset.
- States and codes: inicial=0, preparacao=1, espera=2, transmissao=3, final=4. Codes 5..15 are illegal and go to inicial.
- inicial:
  - Outputs are 0 and ocupado=0.
  - If any pedido bit is set: the arbiter picks a winner, the winner's index and its dados_in slice are registered, and the next state is preparacao.
- preparacao (1 cycle):
  - concedido[winner]=1, zera=1, carrega=1.
  - Baud counter is cleared to 0.
  - Next state is espera.
- espera:
  - tick = (baud counter == BAUD_DIV-1).
  - On tick with fim=0, go to transmissao. On tick with fim=1, go to final. Otherwise stay.
- transmissao (1 cycle): desloca=1, conta=1, then go to espera.
- final (1 cycle): pronto=1. The pointer becomes (winner+1) mod NUM_REQ. Next state is inicial.
- Baud counter:
  - Free-runs 0..BAUD_DIV-1 and wraps to 0 in all states except inicial (held at 0) and preparacao (cleared).
  - It is not disturbed by transmissao, so desloca pulses are spaced exactly BAUD_DIV cycles apart.
- Frame timing, with concedido at cycle 0:
  - First desloca at cycle BAUD_DIV+1.
  - 10 desloca pulses in total.
  - The stop bit is held one full bit period.
  - pronto at cycle 11*BAUD_DIV+1.
  - The earliest next concedido is 2 cycles after pronto (final, then inicial, then preparacao).
- ocupado = 1 in preparacao, espera, transmissao and final.
- dados_ascii:
  - Changes only on entry to preparacao and is stable for the whole frame.
  - Holds its last value after the frame ends.
- Round-robin arbitration: the first set pedido bit at or after the pointer, scanning upward with wrap-around. The pointer advances only in final.
- pedido bits that drop before being granted are ignored. pedido changes during a frame have no effect until inicial.
- fim is sampled only in espera on a tick.

Optional Feature:
TX_PRIORIDADE_FIXA_EN
- Defined: fixed priority, lowest index wins. The pointer is not implemented, and final does not update it.
- Undefined (default): round-robin as described above.

Test Plan:
1. NUM_REQ=2, BAUD_DIV=4, pedido=01, dados_in[6:0]=7'h41.
   - Response: concedido=01 at cycle 0 with carrega=zera=1.
   - 10 desloca pulses at cycles 5, 9, ..., 41.
   - pronto at cycle 45; dados_ascii=7'h41 throughout.
2. After reset, pedido=11 held (word0=7'h41, word1=7'h42).
   - Response: first grant 01, then 10; dados_ascii 41 then 42.
   - Second concedido exactly 2 cycles after the first pronto.
3. pedido=11 held for 4 frames.
   - Response: grants alternate 01, 10, 01, 10; ocupado low exactly 1 cycle between frames.
4. reset=0 at cycle 20 of a frame.
   - Response: on the next cycle db_estado=0 and all outputs are 0.
   - With pedido=10 afterwards, the grant is 10 with the pointer restarted at 0.
5. fim forced to 1 by the bench at the first tick in espera.
   - Response: final on the next cycle, pronto=1, no desloca issued.
6. TX_PRIORIDADE_FIXA_EN defined, pedido=11 held for 3 frames.
   - Response: concedido=01 every frame; requester 1 is never granted.
